// File: rtl/alu_pkg.sv
// Types and widths shared by the ALU front-end blocks.
// No logic here: only the sequencer state type and the common datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 6;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    SETTLE = 2'd2,
    SHOW   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_operand_sequencer_key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-low counter, one-shot press pulse.
// Pulse is issued DEBOUNCE_CYCLES+2 cycles after key_n falls; the key must be seen high again before re-arming.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LOW_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          key_meta;
  logic          key_sync;
  logic          armed;
  logic [CW-1:0] low_cnt;

  // armed starts cleared so a key held through reset cannot fire until released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
      armed    <= 1'b0;
      low_cnt  <= '0;
      press    <= 1'b0;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
      press    <= 1'b0;
      if (key_sync) begin
        low_cnt <= '0;
        armed   <= 1'b1;
      end else if (armed) begin
        if (low_cnt == LOW_LAST) begin
          press   <= 1'b1;
          armed   <= 1'b0;
          low_cnt <= '0;
        end else begin
          low_cnt <= low_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Captures operand A then B from switches on debounced presses, waits SETTLE_CYCLES, registers the ALU result.
// Result lands SETTLE_CYCLES cycles after the B latch edge; presses during SETTLE are dropped.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH           = ALU_WIDTH,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_n,
  input  logic [WIDTH-1:0] sw_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] result_q,
  output logic             result_valid,
  output logic             busy,
  output logic             nA_LED,
  output logic             nB_LED
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] settle_cnt;
  logic             press;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .press(press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD_A;
      alu_a        <= '0;
      alu_b        <= '0;
      result_q     <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      settle_cnt   <= '0;
    end else begin
      case (state)
        LOAD_A: if (press) begin
          alu_a        <= sw_data;
          result_valid <= 1'b0;
          state        <= LOAD_B;
        end
        LOAD_B: if (press) begin
          alu_b      <= sw_data;
          settle_cnt <= '0;
          busy       <= 1'b1;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            result_q     <= alu_result;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= SHOW;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        // A press here starts the next comparison by latching A directly.
        SHOW: if (press) begin
          alu_a        <= sw_data;
          result_valid <= 1'b0;
          state        <= LOAD_B;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  assign nA_LED = alu_a[WIDTH-1];
  assign nB_LED = alu_b[WIDTH-1];

endmodule
